// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - tap table and seed helper for the Fibonacci XNOR LFSR
package lfsr_pkg;

    localparam int LFSR_MIN_W = 2;
    localparam int LFSR_MAX_W = 32;

    // One-hot mask for a 1-indexed tap position
    function automatic logic [31:0] lfsr_tap(input int k);
        return 32'd1 << (k - 1);
    endfunction

    // Maximal-length XNOR tap set for an n-bit register, bit k-1 set for tap k
    function automatic logic [31:0] lfsr_taps(input int n);
        logic [31:0] m;
        case (n)
            2:       m = lfsr_tap(2)  | lfsr_tap(1);
            3:       m = lfsr_tap(3)  | lfsr_tap(2);
            4:       m = lfsr_tap(4)  | lfsr_tap(3);
            5:       m = lfsr_tap(5)  | lfsr_tap(3);
            6:       m = lfsr_tap(6)  | lfsr_tap(5);
            7:       m = lfsr_tap(7)  | lfsr_tap(6);
            8:       m = lfsr_tap(8)  | lfsr_tap(6)  | lfsr_tap(5)  | lfsr_tap(4);
            9:       m = lfsr_tap(9)  | lfsr_tap(5);
            10:      m = lfsr_tap(10) | lfsr_tap(7);
            11:      m = lfsr_tap(11) | lfsr_tap(9);
            12:      m = lfsr_tap(12) | lfsr_tap(6)  | lfsr_tap(4)  | lfsr_tap(1);
            13:      m = lfsr_tap(13) | lfsr_tap(4)  | lfsr_tap(3)  | lfsr_tap(1);
            14:      m = lfsr_tap(14) | lfsr_tap(5)  | lfsr_tap(3)  | lfsr_tap(1);
            15:      m = lfsr_tap(15) | lfsr_tap(14);
            16:      m = lfsr_tap(16) | lfsr_tap(15) | lfsr_tap(13) | lfsr_tap(4);
            17:      m = lfsr_tap(17) | lfsr_tap(14);
            18:      m = lfsr_tap(18) | lfsr_tap(11);
            19:      m = lfsr_tap(19) | lfsr_tap(6)  | lfsr_tap(2)  | lfsr_tap(1);
            20:      m = lfsr_tap(20) | lfsr_tap(17);
            21:      m = lfsr_tap(21) | lfsr_tap(19);
            22:      m = lfsr_tap(22) | lfsr_tap(21);
            23:      m = lfsr_tap(23) | lfsr_tap(18);
            24:      m = lfsr_tap(24) | lfsr_tap(23) | lfsr_tap(22) | lfsr_tap(17);
            25:      m = lfsr_tap(25) | lfsr_tap(22);
            26:      m = lfsr_tap(26) | lfsr_tap(6)  | lfsr_tap(2)  | lfsr_tap(1);
            27:      m = lfsr_tap(27) | lfsr_tap(5)  | lfsr_tap(2)  | lfsr_tap(1);
            28:      m = lfsr_tap(28) | lfsr_tap(25);
            29:      m = lfsr_tap(29) | lfsr_tap(27);
            30:      m = lfsr_tap(30) | lfsr_tap(6)  | lfsr_tap(4)  | lfsr_tap(1);
            31:      m = lfsr_tap(31) | lfsr_tap(28);
            32:      m = lfsr_tap(32) | lfsr_tap(22) | lfsr_tap(2)  | lfsr_tap(1);
            default: m = 32'd0;
        endcase
        return m;
    endfunction

    // Low n bits of the default; all-ones would lock an XNOR LFSR, so swap it for zero
    function automatic logic [31:0] lfsr_seed(input int n, input logic [31:0] dflt);
        logic [31:0] mask;
        logic [31:0] v;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
        v    = dflt & mask;
        return (v == mask) ? 32'd0 : v;
    endfunction

endpackage

// File: rtl/lfsr.sv
// rtl/lfsr.sv - free-running Fibonacci XNOR LFSR, state presented on O_DATA
module lfsr
    import lfsr_pkg::*;
#(
    parameter int          LFSR_DW      = 7,
    parameter logic [31:0] LFSR_DEFAULT = 32'h0000_0000
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [LFSR_DW:0] O_DATA
);

    localparam int          N    = LFSR_DW + 1;
    localparam logic [31:0] TAPS = lfsr_taps(N);
    localparam logic [31:0] SEED = lfsr_seed(N, LFSR_DEFAULT);

    generate
        if (N < LFSR_MIN_W || N > LFSR_MAX_W) begin : g_bad_width
            $error("lfsr: LFSR_DW must be in 1..31");
        end
    endgenerate

    logic [N-1:0] state;
    logic         fb;

    // Feedback is the inverted parity of the tapped bits
    always_comb begin
        fb = ~^(state & TAPS[N-1:0]);
    end

    // State register: reload seed on reset, otherwise shift the feedback in at the LSB
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= SEED[N-1:0];
        end else begin
            state <= {state[N-2:0], fb};
        end
    end

    assign O_DATA = state;

endmodule

// File: tb/tb_lfsr.sv
// tb/tb_lfsr.sv - self-checking bench for lfsr across several widths and seeds
module tb_lfsr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  d8a;
    logic [1:0]  d2;
    logic [7:0]  d8b;
    logic [3:0]  d4;
    logic [15:0] d16;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    lfsr #(.LFSR_DW(7),  .LFSR_DEFAULT(32'h00)) u_d8a (.CLK(clk), .RST(rst), .O_DATA(d8a));
    lfsr #(.LFSR_DW(1),  .LFSR_DEFAULT(32'h00)) u_d2  (.CLK(clk), .RST(rst), .O_DATA(d2));
    lfsr #(.LFSR_DW(7),  .LFSR_DEFAULT(32'hFF)) u_d8b (.CLK(clk), .RST(rst), .O_DATA(d8b));
    lfsr #(.LFSR_DW(3),  .LFSR_DEFAULT(32'h00)) u_d4  (.CLK(clk), .RST(rst), .O_DATA(d4));
    lfsr #(.LFSR_DW(15), .LFSR_DEFAULT(32'h00)) u_d16 (.CLK(clk), .RST(rst), .O_DATA(d16));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference step: shift left, feed in the inverted parity of the listed 1-indexed taps
    function automatic logic [31:0] model_next(input int n, input logic [31:0] s);
        int taps [4];
        logic par;
        logic [31:0] mask;
        case (n)
            2:       taps = '{2, 1, 0, 0};
            4:       taps = '{4, 3, 0, 0};
            8:       taps = '{8, 6, 5, 4};
            default: taps = '{16, 15, 13, 4};
        endcase
        par = 1'b0;
        for (int i = 0; i < 4; i++)
            if (taps[i] != 0) par = par ^ s[taps[i]-1];
        mask = (32'd1 << n) - 32'd1;
        return ((s << 1) | {31'd0, ~par}) & mask;
    endfunction

    // Reference seed: low bits of the default, all-ones replaced by zero
    function automatic logic [31:0] model_seed(input int n, input logic [31:0] dflt);
        logic [31:0] mask;
        mask = (32'd1 << n) - 32'd1;
        return ((dflt & mask) == mask) ? 32'd0 : (dflt & mask);
    endfunction

    logic [31:0] m8a, m2, m8b, m4, m16;
    logic        mvalid = 1'b0;

    // Behavioural model advanced on the same edge as the DUT
    always @(posedge clk) begin
        if (rst) begin
            m8a    <= model_seed(8, 32'h00);
            m2     <= model_seed(2, 32'h00);
            m8b    <= model_seed(8, 32'hFF);
            m4     <= model_seed(4, 32'h00);
            m16    <= model_seed(16, 32'h00);
            mvalid <= 1'b1;
        end else begin
            m8a <= model_next(8, m8a);
            m2  <= model_next(2, m2);
            m8b <= model_next(8, m8b);
            m4  <= model_next(4, m4);
            m16 <= model_next(16, m16);
        end
    end

    // Every-cycle comparison of all instances against the model
    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_d8a", {24'd0, d8a}, m8a);
            chk("model_d2",  {30'd0, d2},  m2);
            chk("model_d8b", {24'd0, d8b}, m8b);
            chk("model_d4",  {28'd0, d4},  m4);
            chk("model_d16", {16'd0, d16}, m16);
            chk("d2_never_3", {31'd0, (d2 == 2'd3)}, 32'd0);
        end
    end

    logic [7:0] exp8 [6];
    logic [1:0] exp2 [6];
    int hist [256];
    int first4, first16;

    initial begin
        exp8 = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        exp2 = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};

        // Reset held for two edges
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_d8a", {24'd0, d8a}, 32'h00);
        chk("rst_d2",  {30'd0, d2},  32'h0);
        chk("rst_d8b_lockup", {24'd0, d8b}, 32'h00);
        chk("rst_d4",  {28'd0, d4},  32'h0);
        chk("rst_d16", {16'd0, d16}, 32'h0);

        // Fresh sequences
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("seq_d8a", {24'd0, d8a}, {24'd0, exp8[i]});
            chk("seq_d8b", {24'd0, d8b}, {24'd0, exp8[i]});
            chk("seq_d2",  {30'd0, d2},  {30'd0, exp2[i]});
        end

        // Period checks
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int v = 0; v < 256; v++) hist[v] = 0;
        first4  = 0;
        first16 = 0;
        for (int k = 1; k <= 65535; k++) begin
            @(negedge clk);
            if (k <= 255) hist[int'(d8a)]++;
            if (k == 255) chk("period8_return", {24'd0, d8a}, 32'h00);
            if (first4 == 0 && d4 == 4'd0) first4 = k;
            if (first16 == 0 && d16 == 16'd0) first16 = k;
        end
        for (int v = 0; v < 256; v++)
            chk($sformatf("hist8_%0h", v), hist[v], (v == 255) ? 32'd0 : 32'd1);
        chk("period4",  first4,  32'd15);
        chk("period16", first16, 32'd65535);

        // Mid-sequence reset pulse
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_d8a", {24'd0, d8a}, 32'h00);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("midrst_seq", {24'd0, d8a}, {24'd0, exp8[i]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
